alu_share_arbiter: RTL



---
 rtl/alu_share_arbiter.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_share_arbiter
// Purpose  : Round-robin sharing of one combinational ALU between two
//            requesters. Operands are registered toward the ALU, the result
//            is captured and returned on a backpressured, tagged response.
// Revision : 1.0 - initial release
// ============================================================================
module alu_share_arbiter #(
    parameter int XLEN = 32,
    parameter int OPW  = 4,
    parameter int RW   = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [OPW-1:0]  req0_op,
    input  logic [XLEN-1:0] req0_a,
    input  logic [XLEN-1:0] req0_b,
    input  logic [RW-1:0]   req0_rd,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [OPW-1:0]  req1_op,
    input  logic [XLEN-1:0] req1_a,
    input  logic [XLEN-1:0] req1_b,
    input  logic [RW-1:0]   req1_rd,
    output logic [OPW-1:0]  alu_op,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    input  logic [XLEN-1:0] alu_result,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_data,
    output logic [RW-1:0]   rsp_rd,
    output logic            rsp_id,
    output logic            rsp_err
);

    // Highest legal ALU op code (SLTU); anything above is reported as error.
    localparam logic [OPW-1:0] C_OP_MAX = OPW'(9);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic            r_last_grant;   // 1: req1 granted last, so req0 wins a tie
    logic [OPW-1:0]  r_alu_op;
    logic [XLEN-1:0] r_alu_a;
    logic [XLEN-1:0] r_alu_b;
    logic [XLEN-1:0] r_rsp_data;
    logic [RW-1:0]   r_rsp_rd;
    logic            r_rsp_id;
    logic            r_rsp_err;

    logic            w_idle;
    logic            w_grant0;
    logic            w_grant1;
    logic            w_accept;
    logic            w_win_id;
    logic [OPW-1:0]  w_win_op;
    logic [XLEN-1:0] w_win_a;
    logic [XLEN-1:0] w_win_b;
    logic [RW-1:0]   w_win_rd;
    logic            w_op_legal;

    // Grants depend only on registered state and request valids, never on
    // rsp_ready, so a response handshake and a new accept cannot share a cycle.
    assign w_idle     = (r_state == ST_IDLE) && !rst;
    assign w_grant0   = w_idle && req0_valid && (!req1_valid || r_last_grant);
    assign w_grant1   = w_idle && req1_valid && !w_grant0;
    assign w_accept   = w_grant0 || w_grant1;
    assign w_win_id   = w_grant1;
    assign w_win_op   = w_grant1 ? req1_op : req0_op;
    assign w_win_a    = w_grant1 ? req1_a  : req0_a;
    assign w_win_b    = w_grant1 ? req1_b  : req0_b;
    assign w_win_rd   = w_grant1 ? req1_rd : req0_rd;
    assign w_op_legal = (w_win_op <= C_OP_MAX);

    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;
    assign alu_op     = r_alu_op;
    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign rsp_valid  = (r_state == ST_RESP);
    assign rsp_data   = r_rsp_data;
    assign rsp_rd     = r_rsp_rd;
    assign rsp_id     = r_rsp_id;
    assign rsp_err    = r_rsp_err;

    // Next-state logic: illegal ops skip EXEC and respond immediately.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = w_op_legal ? ST_EXEC : ST_RESP;
                end
            end
            ST_EXEC: w_state_next = ST_RESP;
            ST_RESP: begin
                if (rsp_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // State register and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_last_grant <= w_win_id;
            end
        end
    end

    // Operand and response holding registers; ALU inputs only move on a
    // legal accept so the shared ALU sees no spurious toggling.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_alu_op   <= '0;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_rsp_data <= '0;
            r_rsp_rd   <= '0;
            r_rsp_id   <= 1'b0;
            r_rsp_err  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_rsp_rd <= w_win_rd;
                r_rsp_id <= w_win_id;
                if (w_op_legal) begin
                    r_alu_op <= w_win_op;
                    r_alu_a  <= w_win_a;
                    r_alu_b  <= w_win_b;
                end else begin
                    r_rsp_data <= '0;
                    r_rsp_err  <= 1'b1;
                end
            end
            if (r_state == ST_EXEC) begin
                r_rsp_data <= alu_result;
                r_rsp_err  <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
